// File: rtl/alu_result_collector_if.sv
// Result-path interface between the ALU output mux / response consumer and
// the result collector. The master side feeds results and accepts heads; the
// slave side is the collector itself.
interface alu_result_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Producer side: registered sub-unit result with one-cycle valid
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  out_valid;
  logic [1:0]            unit_tag;

  // Consumer side: head of the result queue on a valid/ready handshake
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_tag;
  logic                  res_eq;
  logic                  res_gt;
  logic                  res_lt;
  logic                  res_valid;
  logic                  res_ready;

  // Status and control
  logic                  clr_ovf;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;

  modport master (
    output alu_out, out_valid, unit_tag, res_ready, clr_ovf,
    input  res_data, res_tag, res_eq, res_gt, res_lt, res_valid,
           full, empty, count, overflow
  );

  modport slave (
    input  alu_out, out_valid, unit_tag, res_ready, clr_ovf,
    output res_data, res_tag, res_eq, res_gt, res_lt, res_valid,
           full, empty, count, overflow
  );
endinterface

// File: rtl/alu_result_collector.sv
// Captures tagged ALU sub-unit results into a small first-word-fall-through
// FIFO, decoding compare-unit result codes into EQ/GT/LT flags at push time,
// and presents the oldest entry downstream on a valid/ready handshake.
// A result arriving while full (and not being drained) is dropped and
// recorded in a sticky overflow flag.
module alu_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input logic                   clk,
  input logic                   rst,
  alu_result_collector_if.slave bus
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam int         CNT_W   = PTR_W + 1;
  localparam logic [1:0] TAG_CMP = 2'b10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            tag;
    logic                  eq;
    logic                  gt;
    logic                  lt;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  entry_t           wr_entry;
  entry_t           head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still accepts a result when its head leaves in the same cycle.
  assign pop  = !empty && bus.res_ready;
  assign push = bus.out_valid && (!full || pop);
  assign drop = bus.out_valid && full && !pop;

  // Build the entry to store, decoding compare result codes 1/2/3 into flags.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a flag unassigned (no latch).
    wr_entry      = '0;
    wr_entry.data = bus.alu_out;
    wr_entry.tag  = bus.unit_tag;
    if (bus.unit_tag == TAG_CMP && bus.alu_out[DATA_WIDTH-1:2] == '0) begin
      case (bus.alu_out[1:0])
        2'b01:   wr_entry.eq = 1'b1;
        2'b10:   wr_entry.gt = 1'b1;
        2'b11:   wr_entry.lt = 1'b1;
        default: ;
      endcase
    end
  end

  // Storage write; contents are don't-care after reset since count gates visibility.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; only pointers and count are.
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

  // Head entry, forced to zero while empty so outputs read clean.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign bus.res_data  = head.data;
  assign bus.res_tag   = head.tag;
  assign bus.res_eq    = head.eq;
  assign bus.res_gt    = head.gt;
  assign bus.res_lt    = head.lt;
  assign bus.res_valid = !empty;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
Consumer side of the ALU sub-unit result interface. Each sub-unit (arith, logic, cmp, shift) presents a registered result with a one-cycle valid flag; this block captures that result with its unit tag into a small FIFO. It decodes compare-unit result codes into EQ/GT/LT flags and presents the oldest entry downstream on a valid/ready handshake. It sits between the ALU output mux and the register-file/UART response path.

Parameters:
DATA_WIDTH, 16, width of ALU result word.
DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
CLK  input  1  system clock, all state on rising edge.
RST  input  1  asynchronous active-low reset.
ALU_OUT  input  DATA_WIDTH  result word from selected sub-unit.
OUT_VALID  input  1  result valid flag; one push per high cycle.
UNIT_TAG  input  2  source unit: 00 arith, 01 logic, 10 cmp, 11 shift.
RES_DATA  output  DATA_WIDTH  head entry data.
RES_TAG  output  2  head entry unit tag.
RES_EQ  output  1  head is cmp result code 1.
RES_GT  output  1  head is cmp result code 2.
RES_LT  output  1  head is cmp result code 3.
RES_VALID  output  1  head entry available.
RES_READY  input  1  downstream accepts head.
CLR_OVF  input  1  synchronous clear of OVERFLOW.
FULL  output  1  COUNT == DEPTH.
EMPTY  output  1  COUNT == 0.
COUNT  output  clog2(DEPTH)+1  stored entries.
OVERFLOW  output  1  sticky: a valid result was dropped.

Behaviour:
- Reset (RST low, asynchronous): write/read pointers 0, COUNT 0, EMPTY 1, FULL 0, OVERFLOW 0, RES_VALID 0; RES_DATA/RES_TAG/RES_EQ/GT/LT read as 0 while empty. Storage contents are don't-care.
- Push = OUT_VALID && (!FULL || pop). Pop = RES_VALID && RES_READY.
- Each entry stores {data, tag, eq, gt, lt}. Decode happens at push time.
- Decode applies only when UNIT_TAG == 10 and ALU_OUT[DATA_WIDTH-1:2] == 0:
  - low bits 01 -> EQ.
  - 10 -> GT.
  - 11 -> LT.
  - 00 -> none.
- All other cases: EQ/GT/LT = 0. At most one flag is ever high.
- First-word-fall-through. Head fields are driven from the entry at the read pointer. A push at edge k with FIFO empty gives RES_VALID=1 and the entry visible in the cycle after edge k (one-cycle latency).
- RES_VALID = !EMPTY. Head outputs hold stable while RES_VALID && !RES_READY.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- COUNT update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - When full: push is accepted, COUNT stays DEPTH, no overflow.
  - When empty: pop is impossible (RES_VALID=0), push proceeds.
- Overflow: OUT_VALID && FULL && !pop drops the result, FIFO is unchanged, and OVERFLOW is set on the next edge.
- OVERFLOW clears only by CLR_OVF or reset. If a set condition and CLR_OVF occur in the same cycle, set wins.
- FULL, EMPTY and COUNT are registered/derived from registered COUNT and valid the cycle after the causing edge.
- Reset mid-stream discards all entries. RES_VALID drops immediately (asynchronously) and the first push after reset release lands in entry 0.

Test Plan:
- Reset then idle -> EMPTY=1, COUNT=0, RES_VALID=0, OVERFLOW=0. Release RST with OUT_VALID=0 -> values unchanged.
- Push ALU_OUT=0x0002, TAG=10, RES_READY=0 -> next cycle RES_VALID=1, RES_DATA=0x0002, RES_GT=1, EQ=LT=0, COUNT=1. Push 0x0102, TAG=10 -> stored with all flags 0.
- Push 0x1111, 0x2222, 0x3333, 0x4444 (TAG=00) with RES_READY=0 -> FULL=1, COUNT=4. Push 0x5555 -> dropped, OVERFLOW=1. Drain -> order 1111..4444, EMPTY=1. CLR_OVF -> OVERFLOW=0.
- At FULL, push 0xAAAA with RES_READY=1 the same cycle -> head 0x1111 pops, 0xAAAA stored, COUNT stays 4, OVERFLOW stays 0. After 8 push/pop pairs (pointer wrap) -> data order preserved.
- Continuous OUT_VALID and RES_READY for 20 cycles, tags cycling 00..11 -> each result appears with its correct tag one cycle later, COUNT stays <= 1, no overflow.
- 3 entries stored, assert RST low mid-cycle -> RES_VALID=0 and COUNT=0 immediately. After release, push 0x0001 TAG=10 -> RES_EQ=1, COUNT=1.
